// File: rtl/game_flow_ctrl.sv
// Mario coin game sequencer: TITLE/PLAY/OVER/CLEAR flow, restart and banner select.
// Optional banner blinking in TITLE/OVER is enabled by defining BANNER_BLINK_EN.
module game_flow_ctrl #(
  parameter int START_LOCK_FRAMES = 30,
  parameter int OVER_FRAMES       = 180,
  parameter int CLEAR_FRAMES      = 300,
  parameter int BLINK_HALF        = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       game_over,
  input  logic       ending,
  output logic [1:0] game_st,
  output logic       play,
  output logic       new_game,
  output logic [1:0] banner_sel,
  output logic       banner_on
);

  localparam int M0 =
    (START_LOCK_FRAMES > OVER_FRAMES) ?
    START_LOCK_FRAMES : OVER_FRAMES;
  localparam int M1 =
    (CLEAR_FRAMES > BLINK_HALF) ?
    CLEAR_FRAMES : BLINK_HALF;
  localparam int MAXV = (M0 > M1) ? M0 : M1;
  localparam int CW = $clog2(MAXV + 1);

  localparam logic [CW-1:0] LOCK_INIT =
    CW'(START_LOCK_FRAMES);
  localparam logic [CW-1:0] OVER_INIT =
    CW'(OVER_FRAMES);
  localparam logic [CW-1:0] CLEAR_INIT =
    CW'(CLEAR_FRAMES);
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [CW-1:0] ZERO = '0;

  typedef enum logic [1:0] {
    TITLE = 2'd0,
    PLAY  = 2'd1,
    OVER  = 2'd2,
    CLEAR = 2'd3
  } state_t;

  state_t state, next;

  logic          sync1, sync2, sync2_d;
  logic          start_edge;
  logic [CW-1:0] lock, lock_nx;
  logic [CW-1:0] timer, timer_nx;
  logic          play_nx;
  logic          new_game_nx;
  logic [1:0]    banner_sel_nx;
  logic          banner_on_nx;

  // Button is asynchronous: two flops, then a registered rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      sync2_d    <= 1'b0;
      start_edge <= 1'b0;
    end else begin
      sync1      <= start_btn;
      sync2      <= sync1;
      sync2_d    <= sync2;
      start_edge <= sync2 & ~sync2_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= TITLE;
      lock       <= LOCK_INIT;
      timer      <= ZERO;
      play       <= 1'b0;
      new_game   <= 1'b0;
      banner_sel <= 2'd1;
      banner_on  <= 1'b1;
    end else begin
      state      <= next;
      lock       <= lock_nx;
      timer      <= timer_nx;
      play       <= play_nx;
      new_game   <= new_game_nx;
      banner_sel <= banner_sel_nx;
      banner_on  <= banner_on_nx;
    end
  end

  always_comb begin
    next     = state;
    lock_nx  = lock;
    timer_nx = timer;
    unique case (state)
      TITLE: begin
        if (start_edge && lock == ZERO)
          next = PLAY;
        else if (frame_tick && lock != ZERO)
          lock_nx = lock - ONE;
      end
      PLAY: begin
        if (ending)
          next = CLEAR;
        else if (game_over)
          next = OVER;
      end
      OVER, CLEAR: begin
        if (frame_tick) begin
          if (timer == ONE)
            next = TITLE;
          else if (timer != ZERO)
            timer_nx = timer - ONE;
        end
      end
      default: next = TITLE;
    endcase
    // Entry loads win over any decrement in the same cycle.
    if (next != state) begin
      unique case (next)
        TITLE:   lock_nx  = LOCK_INIT;
        OVER:    timer_nx = OVER_INIT;
        CLEAR:   timer_nx = CLEAR_INIT;
        default: ;
      endcase
    end
  end

  always_comb begin
    play_nx     = (next == PLAY);
    new_game_nx = (state == TITLE) && (next == PLAY);
    unique case (next)
      TITLE:   banner_sel_nx = 2'd1;
      PLAY:    banner_sel_nx = 2'd0;
      OVER:    banner_sel_nx = 2'd2;
      CLEAR:   banner_sel_nx = 2'd3;
      default: banner_sel_nx = 2'd1;
    endcase
  end

`ifdef BANNER_BLINK_EN
  localparam logic [CW-1:0] BLINK_LAST =
    CW'(BLINK_HALF - 1);

  logic [CW-1:0] blink, blink_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      blink <= ZERO;
    else
      blink <= blink_nx;
  end

  always_comb begin
    blink_nx     = blink;
    banner_on_nx = banner_on;
    if (next != state) begin
      blink_nx     = ZERO;
      banner_on_nx = (next != PLAY);
    end else begin
      unique case (state)
        TITLE, OVER: begin
          if (frame_tick) begin
            if (blink >= BLINK_LAST) begin
              blink_nx     = ZERO;
              banner_on_nx = ~banner_on;
            end else begin
              blink_nx = blink + ONE;
            end
          end
        end
        PLAY:    banner_on_nx = 1'b0;
        CLEAR:   banner_on_nx = 1'b1;
        default: banner_on_nx = 1'b1;
      endcase
    end
  end
`else
  always_comb begin
    banner_on_nx = (next != PLAY);
  end
`endif

  assign game_st = state;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with a queue scoreboard.
// Observed vector: {game_st, play, new_game, banner_sel, banner_on}.
module tb_game_flow_ctrl;

  logic       clk;
  logic       rst;
  logic       frame_tick;
  logic       start_btn;
  logic       game_over;
  logic       ending;
  logic [1:0] game_st;
  logic       play;
  logic       new_game;
  logic [1:0] banner_sel;
  logic       banner_on;

  int checks = 0;
  int errors = 0;

  string      tag_q[$];
  logic [6:0] exp_q[$];

  game_flow_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .start_btn  (start_btn),
    .game_over  (game_over),
    .ending     (ending),
    .game_st    (game_st),
    .play       (play),
    .new_game   (new_game),
    .banner_sel (banner_sel),
    .banner_on  (banner_on)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] ev(
    input logic [1:0] st,
    input logic       p,
    input logic       ng,
    input logic [1:0] bs,
    input logic       bo
  );
    return {st, p, ng, bs, bo};
  endfunction

  // Banner visibility n ticks after entering TITLE/OVER.
  function automatic logic bon(input int n);
`ifdef BANNER_BLINK_EN
    return ((n / 30) % 2) == 0;
`else
    return 1'b1;
`endif
  endfunction

  task automatic push(input string t, input logic [6:0] e);
    tag_q.push_back(t);
    exp_q.push_back(e);
  endtask

  task automatic compare();
    string      t;
    logic [6:0] e;
    logic [6:0] o;
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    o = {game_st, play, new_game, banner_sel, banner_on};
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", t, o, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
    end
  endtask

  // Edge reaches state 4 clk after the button rises.
  task automatic press();
    start_btn = 1'b1;
    repeat (4) step();
  endtask

  task automatic release_btn();
    start_btn = 1'b0;
    repeat (4) step();
  endtask

  initial begin
    rst        = 1'b1;
    frame_tick = 1'b0;
    start_btn  = 1'b0;
    game_over  = 1'b0;
    ending     = 1'b0;
    repeat (3) step();
    push("reset", ev(2'd0, 0, 0, 2'd1, 1));
    compare();
    rst = 1'b0;
    step();

    ticks(10);
    push("title_t10", ev(2'd0, 0, 0, 2'd1, bon(10)));
    compare();
    game_over = 1'b1;
    ending    = 1'b1;
    step();
    game_over = 1'b0;
    ending    = 1'b0;
    push("title_pulses", ev(2'd0, 0, 0, 2'd1, bon(10)));
    compare();
    press();
    push("locked_start", ev(2'd0, 0, 0, 2'd1, bon(10)));
    compare();
    release_btn();

    ticks(20);
    press();
    push("start_play", ev(2'd1, 1, 1, 2'd0, 0));
    compare();
    step();
    push("new_game_1clk", ev(2'd1, 1, 0, 2'd0, 0));
    compare();
    release_btn();
    press();
    push("play_start", ev(2'd1, 1, 0, 2'd0, 0));
    compare();
    release_btn();

    game_over = 1'b1;
    step();
    game_over = 1'b0;
    push("enter_over", ev(2'd2, 0, 0, 2'd2, 1));
    compare();
    ticks(90);
    ending = 1'b1;
    step();
    ending = 1'b0;
    press();
    push("over_ignore", ev(2'd2, 0, 0, 2'd2, bon(90)));
    compare();
    release_btn();
    ticks(89);
    push("over_t179", ev(2'd2, 0, 0, 2'd2, bon(179)));
    compare();
    ticks(1);
    push("over_to_title", ev(2'd0, 0, 0, 2'd1, 1));
    compare();

    ticks(29);
    press();
    push("relock_t29", ev(2'd0, 0, 0, 2'd1, bon(29)));
    compare();
    release_btn();
    ticks(1);
    press();
    push("play_again", ev(2'd1, 1, 1, 2'd0, 0));
    compare();
    release_btn();

    game_over = 1'b1;
    ending    = 1'b1;
    step();
    game_over = 1'b0;
    ending    = 1'b0;
    push("clear_wins", ev(2'd3, 0, 0, 2'd3, 1));
    compare();
    ticks(150);
    push("clear_t150", ev(2'd3, 0, 0, 2'd3, 1));
    compare();
    ticks(149);
    push("clear_t299", ev(2'd3, 0, 0, 2'd3, 1));
    compare();
    ticks(1);
    push("clear_to_title", ev(2'd0, 0, 0, 2'd1, 1));
    compare();

    ticks(29);
    push("blink_t29", ev(2'd0, 0, 0, 2'd1, bon(29)));
    compare();
    ticks(1);
    push("blink_t30", ev(2'd0, 0, 0, 2'd1, bon(30)));
    compare();
    ticks(29);
    push("blink_t59", ev(2'd0, 0, 0, 2'd1, bon(59)));
    compare();
    ticks(1);
    push("blink_t60", ev(2'd0, 0, 0, 2'd1, bon(60)));
    compare();

    press();
    push("play_3", ev(2'd1, 1, 1, 2'd0, 0));
    compare();
    release_btn();
    game_over = 1'b1;
    step();
    game_over = 1'b0;
    ticks(90);
    push("over_t90", ev(2'd2, 0, 0, 2'd2, bon(90)));
    compare();
    #2;
    rst = 1'b1;
    #1;
    push("async_reset", ev(2'd0, 0, 0, 2'd1, 1));
    compare();
    step();
    step();
    rst = 1'b0;
    step();
    press();
    push("post_rst_lock", ev(2'd0, 0, 0, 2'd1, 1));
    compare();
    release_btn();
    ticks(29);
    press();
    push("post_rst_t29", ev(2'd0, 0, 0, 2'd1, bon(29)));
    compare();
    release_btn();
    ticks(1);
    press();
    push("post_rst_play", ev(2'd1, 1, 1, 2'd0, 0));
    compare();
    release_btn();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
